pkt_queue_ctrl: RTL and testbench

Multi-packet successor to the single-packet ingress controller. It sits between the packet FIFO and the RISC-V core's memory-mapped register window. It detects start-of-packet (SOP) and end-of-packet (EOP) on the ingress control word and queues up to NUM_DESC packet descriptors, so the core can inspect one packet while later packets keep arriving. It then releases each packet, in order, as either pass or drop according to a verdict the core writes.

---
 rtl/pkt_ctrl_pkg.sv | 41 ++++
 rtl/pkt_desc_fifo.sv | 80 ++++++++
 rtl/pkt_queue_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_pkt_queue_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pkt_ctrl_pkg
// Shared definitions for the packet queue controller:
//   - release state encoding (also exposed in the STATUS register)
//   - register window offsets and VERDICT bit positions
//   - packet descriptor layout {sop, eop}
// The descriptor fields are FIFO addresses, sized from PKT_AWIDTH - 2; the
// controller's AWIDTH parameter is expected to match PKT_AWIDTH.
// ----------------------------------------------------------------------------
package pkt_ctrl_pkg;

  localparam int PKT_AWIDTH = 10;
  localparam int FIFO_AW    = PKT_AWIDTH - 2;

  // Encoding is visible to software through STATUS[1:0].
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CPU = 2'd1,
    PASS     = 2'd2,
    DROP     = 2'd3
  } rel_state_t;

  // Register window offsets (addra[7:0]).
  localparam logic [7:0] REG_STATUS   = 8'h00;
  localparam logic [7:0] REG_HEAD_SOP = 8'h01;
  localparam logic [7:0] REG_HEAD_EOP = 8'h02;
  localparam logic [7:0] REG_VERDICT  = 8'h03;
  localparam logic [7:0] REG_COUNT    = 8'h04;
  localparam logic [7:0] REG_PASS_CNT = 8'h05;
  localparam logic [7:0] REG_DROP_CNT = 8'h06;

  // VERDICT write data: bit0 qualifies the write, bit1 selects drop.
  localparam int VERDICT_VALID_BIT = 0;
  localparam int VERDICT_DROP_BIT  = 1;

  typedef struct packed {
    logic [FIFO_AW-1:0] sop;
    logic [FIFO_AW-1:0] eop;
  } desc_t;

endpackage : pkt_ctrl_pkg

// File: rtl/pkt_desc_fifo.sv
// ----------------------------------------------------------------------------
// pkt_desc_fifo
// Small synchronous FIFO holding packet descriptors. First-word-fall-through:
// dout always shows the entry at the read pointer, so the head descriptor is
// visible the cycle after it is written.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear (pointers and count)
//   push, din    write an entry; ignored when full unless a pop happens too
//   pop          remove the head entry; ignored when empty
//   dout         head entry
//   full, empty  occupancy flags
//   count        number of stored entries (0..DEPTH)
//
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module pkt_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted only when the head leaves in the same
  // cycle; otherwise it is dropped rather than corrupting the oldest entry.
  assign do_push = push & (~full | do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;  // idle, or push+pop: occupancy unchanged
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count, so
  // clearing it would only cost a reset net on every bit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule : pkt_desc_fifo

// File: rtl/pkt_queue_ctrl.sv
// ----------------------------------------------------------------------------
// pkt_queue_ctrl
// Multi-packet ingress controller between the packet FIFO and the core's
// memory-mapped register window. Detects SOP/EOP on the ingress control word,
// queues up to NUM_DESC descriptors {sop, eop}, and releases packets in order
// as pass or drop according to a verdict written by the core.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   pc_en               enable; low clears all state at the next edge
//   i_ctrl              ingress control word
//   tail_addr           FIFO write pointer
//   head_addr           FIFO read pointer
//   wea, addra, dina    processor write strobe / address / data
//   douta               registered read data (1-cycle latency)
//   fifo_sel            1: FIFO drains to output, 0: core owns the FIFO
//   drop_packet         discard the packet currently draining
//   stop_tx             hold the FIFO read pointer
//   stall               back-pressure to ingress
//   desc_count          number of queued descriptors
//
// Build option: define PKT_QUEUE_CTRL_STATS_EN to add 32-bit pass/drop
// counters at offsets 0x05/0x06 (write any value to clear). Without it those
// offsets read as zero.
// ----------------------------------------------------------------------------
module pkt_queue_ctrl
  import pkt_ctrl_pkg::*;
#(
  parameter int DWIDTH     = 72,
  parameter int AWIDTH     = PKT_AWIDTH,
  parameter int CTRL_WIDTH = 8,
  parameter int NUM_DESC   = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        pc_en,
  input  logic [CTRL_WIDTH-1:0]       i_ctrl,
  input  logic [AWIDTH-3:0]           tail_addr,
  input  logic [AWIDTH-3:0]           head_addr,
  input  logic                        wea,
  input  logic [AWIDTH-1:0]           addra,
  input  logic [DWIDTH-1:0]           dina,
  output logic [DWIDTH-1:0]           douta,
  output logic                        fifo_sel,
  output logic                        drop_packet,
  output logic                        stop_tx,
  output logic                        stall,
  output logic [$clog2(NUM_DESC):0]   desc_count
);

  localparam int CW = $clog2(NUM_DESC) + 1;
  localparam logic [CTRL_WIDTH-1:0] CTRL_ONES = '1;
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]         CNT_LAST  = CW'(NUM_DESC - 1);

  // --------------------------------------------------------------------------
  // Ingress event detection
  // --------------------------------------------------------------------------
  logic [CTRL_WIDTH-1:0] prev_ctrl;
  logic                  open_pkt;
  logic [FIFO_AW-1:0]    open_sop;
  logic                  sop_evt;
  logic                  eop_evt;

  // SOP: rising into the all-ones control word.
  assign sop_evt = (i_ctrl == CTRL_ONES) && (prev_ctrl != CTRL_ONES);
  // EOP: first non-zero control word after payload words, packet open.
  assign eop_evt = open_pkt && (i_ctrl != '0) && (prev_ctrl == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_ctrl <= '0;
      open_pkt  <= 1'b0;
      open_sop  <= '0;
    end else if (!pc_en) begin
      prev_ctrl <= '0;
      open_pkt  <= 1'b0;
      open_sop  <= '0;
    end else begin
      prev_ctrl <= i_ctrl;
      // A SOP coinciding with an EOP closes the old packet (its descriptor
      // is pushed below) and immediately opens the next one.
      if (sop_evt) begin
        open_pkt <= 1'b1;
        open_sop <= tail_addr;
      end else if (eop_evt) begin
        open_pkt <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Descriptor queue
  // --------------------------------------------------------------------------
  desc_t push_desc;
  desc_t head;
  logic  q_full;
  logic  q_empty;
  logic  pop_req;

  assign push_desc = '{sop: open_sop, eop: tail_addr};

  pkt_desc_fifo #(
    .DEPTH (NUM_DESC),
    .WIDTH ($bits(desc_t))
  ) u_desc_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (~pc_en),
    .push  (eop_evt),
    .din   (push_desc),
    .pop   (pop_req),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (desc_count)
  );

  // Asserts in the EOP cycle that fills the last slot, so ingress sees it
  // before the queue is actually full; releases once the registered count
  // drops.
  assign stall = q_full | ((desc_count == CNT_LAST) & eop_evt & ~pop_req);

  // --------------------------------------------------------------------------
  // Register window decode
  // --------------------------------------------------------------------------
  logic       blk_sel;
  logic [7:0] reg_off;
  logic       verdict_wr;

  assign blk_sel    = addra[AWIDTH-1];
  assign reg_off    = addra[7:0];
  assign verdict_wr = wea & blk_sel & (reg_off == REG_VERDICT)
                    & dina[VERDICT_VALID_BIT];

  // --------------------------------------------------------------------------
  // Release FSM
  // --------------------------------------------------------------------------
  rel_state_t state;
  rel_state_t state_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (!pc_en) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    fifo_sel    = 1'b1;
    drop_packet = 1'b0;
    stop_tx     = 1'b0;
    pop_req     = 1'b0;

    case (state)
      IDLE: begin
        // Hold the reader at the start of a packet still being written.
        stop_tx = open_pkt && (head_addr == open_sop);
        // Enter WAIT_CPU on the same edge that makes the descriptor visible.
        if (eop_evt || !q_empty) state_nxt = WAIT_CPU;
      end

      WAIT_CPU: begin
        fifo_sel = 1'b0;
        stop_tx  = (head_addr == head.sop);
        if (verdict_wr) begin
          state_nxt = dina[VERDICT_DROP_BIT] ? DROP : PASS;
        end
      end

      PASS, DROP: begin
        drop_packet = (state == DROP);
        // Equality on the wrapped pointer handles packets crossing the end
        // of the FIFO address space.
        if (head_addr == head.eop) begin
          pop_req = 1'b1;
          // Entries remaining after this pop, including one pushed now.
          state_nxt = ((desc_count > CNT_ONE) || eop_evt) ? WAIT_CPU : IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Optional statistics
  // --------------------------------------------------------------------------
`ifdef PKT_QUEUE_CTRL_STATS_EN
  logic [31:0] pass_cnt;
  logic [31:0] drop_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pass_cnt <= '0;
      drop_cnt <= '0;
    end else if (!pc_en) begin
      pass_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      // A software clear wins over a same-cycle increment.
      if (wea && blk_sel && (reg_off == REG_PASS_CNT)) begin
        pass_cnt <= '0;
      end else if (pop_req && (state == PASS)) begin
        pass_cnt <= pass_cnt + 32'd1;
      end

      if (wea && blk_sel && (reg_off == REG_DROP_CNT)) begin
        drop_cnt <= '0;
      end else if (pop_req && (state == DROP)) begin
        drop_cnt <= drop_cnt + 32'd1;
      end
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  logic [DWIDTH-1:0] rdata;

  always_comb begin
    rdata = '0;
    if (blk_sel) begin
      case (reg_off)
        REG_STATUS:   rdata[4:0]         = {q_full, q_empty, open_pkt, state};
        REG_HEAD_SOP: rdata[FIFO_AW-1:0] = head.sop;
        REG_HEAD_EOP: rdata[FIFO_AW-1:0] = head.eop;
        REG_COUNT:    rdata[CW-1:0]      = desc_count;
`ifdef PKT_QUEUE_CTRL_STATS_EN
        REG_PASS_CNT: rdata[31:0]        = pass_cnt;
        REG_DROP_CNT: rdata[31:0]        = drop_cnt;
`endif
        default:      rdata              = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      douta <= '0;
    end else if (!pc_en) begin
      douta <= '0;
    end else begin
      douta <= rdata;
    end
  end

  // Write data above the verdict bits and address bits between the offset
  // field and the block select carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{dina[DWIDTH-1:2], addra[AWIDTH-2:8]};

endmodule : pkt_queue_ctrl

// File: tb/tb_pkt_queue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pkt_queue_ctrl
// Directed bench for pkt_queue_ctrl. Register reads go through a scoreboard
// queue (expected value pushed when the address is driven, popped when douta
// is valid); descriptors are tracked in a second queue in arrival order.
// Compile with +define+PKT_QUEUE_CTRL_STATS_EN to exercise the counters.
// ----------------------------------------------------------------------------
module tb_pkt_queue_ctrl;

  localparam logic [9:0] A_STATUS   = 10'h200;
  localparam logic [9:0] A_HEAD_SOP = 10'h201;
  localparam logic [9:0] A_HEAD_EOP = 10'h202;
  localparam logic [9:0] A_VERDICT  = 10'h203;
  localparam logic [9:0] A_COUNT    = 10'h204;
  localparam logic [9:0] A_PASS_CNT = 10'h205;
  localparam logic [9:0] A_DROP_CNT = 10'h206;
  localparam logic [9:0] A_UNMAPPED = 10'h207;
  localparam logic [9:0] A_NOT_BLK  = 10'h000;

  // STATUS values {full, empty, open_pkt, state[1:0]}
  localparam logic [71:0] ST_IDLE_EMPTY = 72'h08;
  localparam logic [71:0] ST_WAIT_ONE   = 72'h01;
  localparam logic [71:0] ST_WAIT_FULL  = 72'h11;

`ifdef PKT_QUEUE_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [7:0] sop;
    logic [7:0] eop;
  } tdesc_t;

  logic        clk;
  logic        reset_n;
  logic        pc_en;
  logic [7:0]  i_ctrl;
  logic [7:0]  tail_addr;
  logic [7:0]  head_addr;
  logic        wea;
  logic [9:0]  addra;
  logic [71:0] dina;
  logic [71:0] douta;
  logic        fifo_sel;
  logic        drop_packet;
  logic        stop_tx;
  logic        stall;
  logic [2:0]  desc_count;

  int          total;
  int          bad;
  logic [71:0] rq[$];
  tdesc_t      desc_q[$];
  logic [7:0]  cur_sop;

  pkt_queue_ctrl #(
    .DWIDTH     (72),
    .AWIDTH     (10),
    .CTRL_WIDTH (8),
    .NUM_DESC   (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pc_en       (pc_en),
    .i_ctrl      (i_ctrl),
    .tail_addr   (tail_addr),
    .head_addr   (head_addr),
    .wea         (wea),
    .addra       (addra),
    .dina        (dina),
    .douta       (douta),
    .fifo_sel    (fifo_sel),
    .drop_packet (drop_packet),
    .stop_tx     (stop_tx),
    .stall       (stall),
    .desc_count  (desc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Register read: expectation enters the scoreboard when the address is
  // driven and is compared when douta becomes valid one edge later.
  task automatic rd(input logic [9:0] addr, input string tag, input logic [71:0] exp);
    wea   = 1'b0;
    addra = addr;
    rq.push_back(exp);
    cyc();
    check(tag, douta, rq.pop_front());
  endtask

  task automatic wr(input logic [9:0] addr, input logic [71:0] data);
    wea   = 1'b1;
    addra = addr;
    dina  = data;
    cyc();
    wea   = 1'b0;
    dina  = '0;
  endtask

  // SOP word then one payload word.
  task automatic pkt_open(input logic [7:0] sop);
    cur_sop   = sop;
    i_ctrl    = 8'hFF;
    tail_addr = sop;
    cyc();
    i_ctrl    = 8'h00;
    tail_addr = sop + 8'd1;
    cyc();
  endtask

  // EOP word; stall is checked inside the EOP cycle.
  task automatic pkt_eop(input logic [7:0] eop, input logic exp_stall, input string tag);
    tdesc_t d;
    i_ctrl    = 8'h01;
    tail_addr = eop;
    #1;
    check(tag, stall, exp_stall);
    d.sop = cur_sop;
    d.eop = eop;
    desc_q.push_back(d);
    cyc();
    i_ctrl = 8'h00;
  endtask

  // A push into a full queue must never happen: stall is meant to prevent it.
  always @(negedge clk) begin
    if (reset_n && pc_en && dut.eop_evt && dut.q_full && !dut.pop_req) begin
      bad++;
      $error("FAIL push_while_full observed=1 expected=0");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    pc_en     = 1'b1;
    i_ctrl    = '0;
    tail_addr = '0;
    head_addr = 8'h10;
    wea       = 1'b0;
    addra     = '0;
    dina      = '0;
    cur_sop   = '0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_fifo_sel", fifo_sel, 1'b1);
    check("rst_drop", drop_packet, 1'b0);
    check("rst_stop_tx", stop_tx, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_count", desc_count, 3'd0);
    check("rst_douta", douta, '0);
    reset_n = 1'b1;
    cyc();
    rd(A_STATUS, "rst_status", ST_IDLE_EMPTY);

    // ---- single packet ----
    pkt_open(8'h10);
    check("idle_open_stop_tx", stop_tx, 1'b1);
    pkt_eop(8'h20, 1'b0, "p1_eop_stall");
    check("p1_count", desc_count, 3'd1);
    check("p1_fifo_sel", fifo_sel, 1'b0);
    check("p1_stop_tx", stop_tx, 1'b1);
    rd(A_STATUS, "p1_status", ST_WAIT_ONE);
    rd(A_COUNT, "p1_count_reg", 72'd1);
    rd(A_HEAD_SOP, "p1_head_sop", 72'(desc_q[0].sop));
    rd(A_HEAD_EOP, "p1_head_eop", 72'(desc_q[0].eop));
    head_addr = 8'h11;
    #1;
    check("p1_stop_tx_moved", stop_tx, 1'b0);

    // ---- pass verdict ----
    wr(A_VERDICT, 72'h1);
    check("pass_fifo_sel", fifo_sel, 1'b1);
    check("pass_drop", drop_packet, 1'b0);
    check("pass_stop_tx", stop_tx, 1'b0);
    head_addr = 8'h1F;
    cyc();
    check("pass_not_done", desc_count, 3'd1);
    head_addr = 8'h20;
    #1;
    check("pass_pop_pending", desc_count, 3'd1);
    cyc();
    void'(desc_q.pop_front());
    check("pass_popped", desc_count, 3'd0);
    rd(A_STATUS, "pass_idle", ST_IDLE_EMPTY);
    wr(A_VERDICT, 72'h1);
    rd(A_STATUS, "verdict_in_idle_ignored", ST_IDLE_EMPTY);

    // ---- drop verdict ----
    pkt_open(8'h30);
    pkt_eop(8'h40, 1'b0, "p2_eop_stall");
    head_addr = 8'h30;
    wr(A_VERDICT, 72'h2);
    check("verdict_no_valid_ignored", fifo_sel, 1'b0);
    wr(A_VERDICT, 72'h3);
    check("drop_fifo_sel", fifo_sel, 1'b1);
    check("drop_active", drop_packet, 1'b1);
    head_addr = 8'h35;
    cyc();
    check("drop_still", drop_packet, 1'b1);
    head_addr = 8'h40;
    #1;
    check("drop_at_eop", drop_packet, 1'b1);
    cyc();
    void'(desc_q.pop_front());
    check("drop_done", drop_packet, 1'b0);
    check("drop_count", desc_count, 3'd0);

    // ---- queue fill ----
    head_addr = 8'h50;
    pkt_open(8'h50); pkt_eop(8'h58, 1'b0, "fill1_stall");
    pkt_open(8'h60); pkt_eop(8'h68, 1'b0, "fill2_stall");
    pkt_open(8'h70); pkt_eop(8'h78, 1'b0, "fill3_stall");
    pkt_open(8'h80); pkt_eop(8'h88, 1'b1, "fill4_stall");
    check("full_stall", stall, 1'b1);
    rd(A_STATUS, "full_status", ST_WAIT_FULL);
    rd(A_COUNT, "full_count", 72'd4);
    rd(A_HEAD_SOP, "full_head_sop", 72'(desc_q[0].sop));
    wr(A_VERDICT, 72'h1);
    head_addr = 8'h58;
    #1;
    check("full_stall_before_pop", stall, 1'b1);
    cyc();
    void'(desc_q.pop_front());
    check("stall_after_pop", stall, 1'b0);
    check("count_after_pop", desc_count, 3'd3);
    check("wait_after_pop", fifo_sel, 1'b0);
    rd(A_HEAD_SOP, "next_head_sop", 72'(desc_q[0].sop));
    for (int i = 0; i < 3; i++) begin
      head_addr = desc_q[0].sop;
      wr(A_VERDICT, 72'h1);
      head_addr = desc_q[0].eop;
      cyc();
      void'(desc_q.pop_front());
      check("drain_count", desc_count, 3'(desc_q.size()));
    end
    rd(A_STATUS, "drained_status", ST_IDLE_EMPTY);

    // ---- wrap-around and simultaneous push/pop ----
    pkt_open(8'hF8);
    pkt_eop(8'h08, 1'b0, "wrap_eop_stall");
    head_addr = 8'hF8;
    wr(A_VERDICT, 72'h1);
    head_addr = 8'hFC;
    cyc();
    check("wrap_pre_count", desc_count, 3'd1);
    check("wrap_pre_sel", fifo_sel, 1'b1);
    head_addr = 8'h02;
    cyc();
    pkt_open(8'h10);
    check("wrap_post_wrap_count", desc_count, 3'd1);
    head_addr = 8'h08;
    pkt_eop(8'h20, 1'b0, "pushpop_stall");
    void'(desc_q.pop_front());
    check("pushpop_count", desc_count, 3'd1);
    check("pushpop_wait", fifo_sel, 1'b0);
    rd(A_HEAD_SOP, "pushpop_head_sop", 72'(desc_q[0].sop));
    rd(A_HEAD_EOP, "pushpop_head_eop", 72'(desc_q[0].eop));

    // ---- register map edges and statistics ----
    rd(A_UNMAPPED, "unmapped_zero", 72'd0);
    rd(A_NOT_BLK, "not_selected_zero", 72'd0);
    rd(A_PASS_CNT, "pass_cnt", STATS ? 72'd6 : 72'd0);
    rd(A_DROP_CNT, "drop_cnt", STATS ? 72'd1 : 72'd0);
    wr(A_DROP_CNT, 72'h5);
    rd(A_DROP_CNT, "drop_cnt_cleared", 72'd0);

    // ---- asynchronous reset in PASS ----
    head_addr = 8'h10;
    wr(A_VERDICT, 72'h1);
    rd(A_COUNT, "pre_reset_count", 72'd1);
    check("pre_reset_douta", douta, 72'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_douta", douta, '0);
    check("areset_count", desc_count, 3'd0);
    check("areset_fifo_sel", fifo_sel, 1'b1);
    check("areset_drop", drop_packet, 1'b0);
    check("areset_stop_tx", stop_tx, 1'b0);
    check("areset_stall", stall, 1'b0);
    desc_q.delete();
    cyc();
    reset_n = 1'b1;
    cyc();
    rd(A_PASS_CNT, "pass_cnt_after_reset", 72'd0);
    rd(A_STATUS, "status_after_reset", ST_IDLE_EMPTY);

    // ---- pc_en low clears state ----
    pkt_open(8'h40);
    pkt_eop(8'h48, 1'b0, "pcen_eop_stall");
    check("pcen_pre_count", desc_count, 3'd1);
    pc_en = 1'b0;
    cyc();
    desc_q.delete();
    check("pcen_count", desc_count, 3'd0);
    check("pcen_fifo_sel", fifo_sel, 1'b1);
    check("pcen_douta", douta, '0);
    pc_en = 1'b1;
    rd(A_STATUS, "pcen_status", ST_IDLE_EMPTY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pkt_queue_ctrl
